spi_reply_sched: RTL and testbench

Reply scheduler between the SPI slave byte interface and the on-chip responders (lab FSM, status sources). The block decodes each received byte: a poll or flush command, or a data byte forwarded to the FSM. It arbitrates round-robin among requesters that want to return a byte, queues granted bytes in a small FIFO, and arms the SPI slave's TX buffer with exactly one reply byte per received byte.

---
 rtl/spi_reply_sched.sv | 200 ++++++++++++++++++++
 tb/tb_spi_reply_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_reply_sched.sv
// Reply scheduler for the SPI slave: decodes received bytes, round-robin queues requester bytes,
// and arms one TX byte per received byte. Optional macro SPI_REPLY_SCHED_UNDERFLOW_CNT_EN adds o_Underflow_Cnt.
module spi_reply_sched #(
    parameter int         NUM_REQ    = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CMD_POLL   = 8'hFF,
    parameter logic [7:0] CMD_FLUSH  = 8'hFE,
    parameter logic [7:0] FILL_BYTE  = 8'h00
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    input  logic                            i_RX_DV,
    input  logic [7:0]                      i_RX_Byte,
    output logic                            o_TX_DV,
    output logic [7:0]                      o_TX_Byte,
    output logic                            o_Data_DV,
    output logic [7:0]                      o_Data_Byte,
`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
    output logic [7:0]                      o_Underflow_Cnt,
`endif
    input  logic [NUM_REQ-1:0]              i_Req,
    input  logic [8*NUM_REQ-1:0]            i_Req_Data,
    output logic [NUM_REQ-1:0]              o_Gnt,
    output logic [$clog2(FIFO_DEPTH):0]     o_Level,
    output logic                            o_Full,
    output logic                            o_Empty
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {S_LOAD = 1'b0, S_ARMED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            tx_dv_q, tx_dv_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            data_dv_q, data_dv_d;
    logic [7:0]      data_byte_q, data_byte_d;
    logic            flush_q, flush_d;
    logic [RRW-1:0]  rr_q, rr_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]   level_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            full_s, empty_s, pop_s, flush_cycle_s, push_ok_s, push_s, uf_inc_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [7:0]      push_data_s;
    logic            found_s;
    int              idx_s;

    assign full_s        = (level_q == LW'(FIFO_DEPTH));
    assign empty_s       = (level_q == LW'(0));
    assign flush_cycle_s = (state_q == S_LOAD) && flush_q;
    assign pop_s         = (state_q == S_LOAD) && !flush_q && !empty_s;
    assign push_ok_s     = !flush_cycle_s && (!full_s || pop_s);
    assign push_s        = |gnt_s;

    // Round-robin search from rr; grant held low while in reset so outputs match reset values
    always_comb begin
        gnt_s       = '0;
        rr_d        = rr_q;
        push_data_s = FILL_BYTE;
        found_s     = 1'b0;
        idx_s       = 0;
        if (push_ok_s && i_Rst_L) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_s = (int'(rr_q) + i) % NUM_REQ;
                if (!found_s && i_Req[idx_s]) begin
                    found_s      = 1'b1;
                    gnt_s[idx_s] = 1'b1;
                    push_data_s  = i_Req_Data[8*idx_s +: 8];
                    rr_d         = RRW'((idx_s + 1) % NUM_REQ);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            gnt_s = '0;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        data_dv_d   = 1'b0;
        data_byte_d = data_byte_q;
        flush_d     = flush_q;
        uf_inc_s    = 1'b0;
        case (state_q)
            S_LOAD: begin
                tx_dv_d = 1'b1;
                if (pop_s) begin
                    tx_byte_d = mem_q[rd_ptr_q];
                end else begin
                    tx_byte_d = FILL_BYTE;
                    uf_inc_s  = !flush_q;
                end
                flush_d = 1'b0;
                state_d = S_ARMED;
            end
            S_ARMED: begin
                if (i_RX_DV) begin
                    state_d = S_LOAD;
                    if (i_RX_Byte == CMD_POLL) begin
                        flush_d = flush_q;
                    end else if (i_RX_Byte == CMD_FLUSH) begin
                        flush_d = 1'b1;
                    end else begin
                        data_dv_d   = 1'b1;
                        data_byte_d = i_RX_Byte;
                    end
                end else begin
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // FSM state, output registers and arbitration pointer
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= S_LOAD;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= FILL_BYTE;
            data_dv_q   <= 1'b0;
            data_byte_q <= 8'h00;
            flush_q     <= 1'b0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            data_dv_q   <= data_dv_d;
            data_byte_q <= data_byte_d;
            flush_q     <= flush_d;
            rr_q        <= rr_d;
        end
    end

    // Reply queue; a flush cycle empties it and suppresses any push
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= FILL_BYTE;
            end
        end else if (flush_cycle_s) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_s;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
    logic [7:0] uf_cnt_q;

    // Saturating count of loads that armed the fill byte from an empty queue
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            uf_cnt_q <= 8'h00;
        end else if (uf_inc_s && (uf_cnt_q != 8'hFF)) begin
            uf_cnt_q <= uf_cnt_q + 8'd1;
        end else begin
            uf_cnt_q <= uf_cnt_q;
        end
    end

    assign o_Underflow_Cnt = uf_cnt_q;
`else
    logic unused_uf_s;
    assign unused_uf_s = uf_inc_s;
`endif

    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Data_DV   = data_dv_q;
    assign o_Data_Byte = data_byte_q;
    assign o_Gnt       = gnt_s;
    assign o_Level     = level_q;
    assign o_Full      = full_s;
    assign o_Empty     = empty_s;
endmodule

// File: tb/tb_spi_reply_sched.sv
// Scoreboard bench for spi_reply_sched: expected TX/data bytes are queued by the stimulus
// and consumed by a monitor whenever the DUT pulses o_TX_DV or o_Data_DV.
module tb_spi_reply_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        data_dv;
    logic [7:0]  data_byte;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  gnt;
    logic [2:0]  level;
    logic        full, empty;
`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
    logic [7:0]  uf_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_data[$];

    spi_reply_sched dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .o_Data_DV(data_dv), .o_Data_Byte(data_byte),
`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
        .o_Underflow_Cnt(uf_cnt),
`endif
        .i_Req(req), .i_Req_Data(req_data), .o_Gnt(gnt), .o_Level(level),
        .o_Full(full), .o_Empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with the DUT armed; returns at posedge+1 with the DUT re-armed
    task automatic rx(input logic [7:0] b);
        logic is_data;
        is_data = (b != 8'hFF) && (b != 8'hFE);
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        chk("data_dv_latency", {31'd0, data_dv}, {31'd0, is_data});
        @(posedge clk); #1;
        chk("tx_dv_rearm", {31'd0, tx_dv}, 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tx_dv"}, {31'd0, tx_dv}, 32'd0);
        chk({tag, "_tx_byte"}, {24'd0, tx_byte}, 32'h00);
        chk({tag, "_data_dv"}, {31'd0, data_dv}, 32'd0);
        chk({tag, "_data_byte"}, {24'd0, data_byte}, 32'h00);
        chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        chk({tag, "_level"}, {29'd0, level}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
        chk({tag, "_uf_cnt"}, {24'd0, uf_cnt}, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; req = 2'b00; req_data = 16'h0000;
        fork
            // Monitor: compare every TX arm and data forward against the scoreboard
            forever begin
                @(negedge clk);
                if (rst_n && tx_dv) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                    else chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx.pop_front()});
                end
                if (rst_n && data_dv) begin
                    if (exp_data.size() == 0) chk("data_unexpected", 32'd1, 32'd0);
                    else chk("data_byte", {24'd0, data_byte}, {24'd0, exp_data.pop_front()});
                end
            end
            begin
                #2 reset_checks("rst");
                @(negedge clk); #1 rst_n = 1'b1;
                exp_tx.push_back(8'h00);
                @(posedge clk); #1;
                chk("first_tx_dv", {31'd0, tx_dv}, 32'd1);

                // Data byte forwarded, fill re-armed
                exp_data.push_back(8'h3C);
                exp_tx.push_back(8'h00);
                rx(8'h3C);

                // Single push then poll returns it
                req = 2'b01; req_data = 16'h22A5;
                #1 chk("gnt_single", {30'd0, gnt}, 32'd1);
                @(posedge clk); #1;
                req = 2'b00;
                chk("level_one", {29'd0, level}, 32'd1);
                exp_tx.push_back(8'hA5);
                rx(8'hFF);
                chk("level_after_pop", {29'd0, level}, 32'd0);

                // Both requesting: rr is 1 after the previous grant, so 1,0,1,0
                req = 2'b11; req_data = 16'h2211;
                for (int k = 0; k < 4; k++) begin
                    #1 chk("gnt_alternate", {30'd0, gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
                    @(posedge clk); #1;
                end
                chk("level_full", {29'd0, level}, 32'd4);
                chk("full_flag", {31'd0, full}, 32'd1);
                chk("gnt_blocked", {30'd0, gnt}, 32'd0);
                exp_tx.push_back(8'h22);
                rx_dv = 1'b1; rx_byte = 8'hFF;
                @(posedge clk); #1;
                rx_dv = 1'b0;
                chk("gnt_on_pop", {30'd0, gnt}, 32'd2);
                @(posedge clk); #1;
                req = 2'b00;
                chk("level_push_pop", {29'd0, level}, 32'd4);

                // Pop one to leave 3, then flush
                exp_tx.push_back(8'h11);
                rx(8'hFF);
                chk("level_three", {29'd0, level}, 32'd3);
                exp_tx.push_back(8'h00);
                rx(8'hFE);
                chk("level_flush", {29'd0, level}, 32'd0);
                chk("empty_flush", {31'd0, empty}, 32'd1);
`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
                chk("uf_after_flush", {24'd0, uf_cnt}, 32'd2);
`endif
                for (int k = 0; k < 4; k++) begin
                    exp_tx.push_back(8'h00);
                    rx(8'hFF);
                end
`ifdef SPI_REPLY_SCHED_UNDERFLOW_CNT_EN
                chk("uf_four_polls", {24'd0, uf_cnt}, 32'd6);
                for (int k = 0; k < 300; k++) begin
                    exp_tx.push_back(8'h00);
                    rx(8'hFF);
                end
                chk("uf_saturate", {24'd0, uf_cnt}, 32'hFF);
`endif

                // Reset mid-operation with two bytes queued and a grant pending
                req = 2'b01; req_data = 16'h005A;
                @(posedge clk); #1;
                @(posedge clk); #1;
                chk("pre_rst_level", {29'd0, level}, 32'd2);
                chk("pre_rst_gnt", {30'd0, gnt}, 32'd1);
                #1 rst_n = 1'b0;
                #1 reset_checks("midrst");
                req = 2'b00;
                @(negedge clk); #1 rst_n = 1'b1;
                exp_tx.push_back(8'h00);
                @(posedge clk); #1;
                chk("post_rst_tx", {24'd0, tx_byte}, 32'h00);
                repeat (3) @(posedge clk);
                #1;
                chk("tx_queue_drained", exp_tx.size(), 32'd0);
                chk("data_queue_drained", exp_data.size(), 32'd0);
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
